// File: rtl/gray_ctrl_pkg.sv
// Shared types for the gray-converter frame controller: FSM state encoding
// and the default camera geometry.
package gray_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2,
        RESYNC   = 2'd3
    } state_t;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

endpackage

// File: rtl/gray_frame_ctrl_if.sv
// Video handshake bundle: camera AXI4-Stream input side and converter output side.
// The slave modport is the frame controller; the master modport is its surroundings.
interface gray_frame_ctrl_if #(
    parameter int AXI_WIDTH = 24
) ();

    logic [AXI_WIDTH-1:0] s_axi_video_tdata;
    logic                 s_axi_video_tvalid;
    logic                 s_axi_video_tuser;
    logic                 s_axi_video_tlast;
    logic                 s_axi_video_tready;

    logic [AXI_WIDTH-1:0] m_conv_tdata;
    logic                 m_conv_tvalid;
    logic                 m_conv_tuser;
    logic                 m_conv_tlast;
    logic                 m_conv_tready;

    modport slave (
        input  s_axi_video_tdata,
        input  s_axi_video_tvalid,
        input  s_axi_video_tuser,
        input  s_axi_video_tlast,
        output s_axi_video_tready,
        output m_conv_tdata,
        output m_conv_tvalid,
        output m_conv_tuser,
        output m_conv_tlast,
        input  m_conv_tready
    );

    modport master (
        output s_axi_video_tdata,
        output s_axi_video_tvalid,
        output s_axi_video_tuser,
        output s_axi_video_tlast,
        input  s_axi_video_tready,
        input  m_conv_tdata,
        input  m_conv_tvalid,
        input  m_conv_tuser,
        input  m_conv_tlast,
        output m_conv_tready
    );

endinterface

// File: rtl/gray_frame_ctrl.sv
// Frame controller ahead of the RGB-to-gray converter: locks onto SOF, forwards
// only geometry-checked frames through a one-deep output register, flags framing errors.
module gray_frame_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int AXI_WIDTH  = 24,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    gray_frame_ctrl_if.slave  vid,
    output logic              frame_start,
    output logic              frame_done,
    output logic              err_line,
    output logic              err_sof,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [15:0]       frame_cnt
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    state_t               r_state;
    logic [AXI_WIDTH-1:0] r_m_tdata;
    logic                 r_m_tvalid;
    logic                 r_m_tuser;
    logic                 r_m_tlast;
    logic                 r_frame_start;
    logic                 r_frame_done;
    logic                 r_err_line;
    logic                 r_err_sof;
    logic [COL_W-1:0]     r_col;
    logic [ROW_W-1:0]     r_row;
    logic [15:0]          r_frame_cnt;

    logic w_slot_free;
    logic w_tready;
    logic w_acc;
    logic w_col_last;
    logic w_row_last;
    logic w_at_origin;

    // The output slot can take a new beat when empty or being drained this cycle.
    assign w_slot_free = !r_m_tvalid || vid.m_conv_tready;
    assign w_tready    = !rst && (r_state != IDLE) && w_slot_free;
    assign w_acc       = vid.s_axi_video_tvalid && w_tready;
    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_last  = (r_row == ROW_LAST);
    assign w_at_origin = (r_col == COL_ZERO) && (r_row == ROW_ZERO);

    assign vid.s_axi_video_tready = w_tready;
    assign vid.m_conv_tdata       = r_m_tdata;
    assign vid.m_conv_tvalid      = r_m_tvalid;
    assign vid.m_conv_tuser       = r_m_tuser;
    assign vid.m_conv_tlast       = r_m_tlast;

    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign err_line    = r_err_line;
    assign err_sof     = r_err_sof;
    assign col         = r_col;
    assign row         = r_row;
    assign frame_cnt   = r_frame_cnt;

    // Frame FSM, position counters, event pulses and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_m_tdata     <= {AXI_WIDTH{1'b0}};
            r_m_tvalid    <= 1'b0;
            r_m_tuser     <= 1'b0;
            r_m_tlast     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_line    <= 1'b0;
            r_err_sof     <= 1'b0;
            r_col         <= COL_ZERO;
            r_row         <= ROW_ZERO;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_line    <= 1'b0;
            r_err_sof     <= 1'b0;
            // Slot empties once drained; a forwarded beat below overrides this.
            if (w_slot_free) begin
                r_m_tvalid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= WAIT_SOF;
                    end
                end
                WAIT_SOF, RESYNC: begin
                    if ((r_state == RESYNC) && !enable) begin
                        r_state <= IDLE;
                    end else if (w_acc && vid.s_axi_video_tuser) begin
                        r_m_tvalid    <= 1'b1;
                        r_m_tdata     <= vid.s_axi_video_tdata;
                        r_m_tuser     <= 1'b1;
                        r_m_tlast     <= 1'b0;
                        r_frame_start <= 1'b1;
                        r_col         <= COL_ONE;
                        r_row         <= ROW_ZERO;
                        r_state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_acc) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= vid.s_axi_video_tdata;
                        if (vid.s_axi_video_tuser && !w_at_origin) begin
                            // Early SOF wins over any line error on the same beat.
                            r_m_tuser     <= 1'b1;
                            r_m_tlast     <= 1'b0;
                            r_err_sof     <= 1'b1;
                            r_frame_start <= 1'b1;
                            r_col         <= COL_ONE;
                            r_row         <= ROW_ZERO;
                        end else begin
                            r_m_tuser <= 1'b0;
                            r_m_tlast <= w_col_last || vid.s_axi_video_tlast;
                            if (w_col_last && vid.s_axi_video_tlast) begin
                                r_col <= COL_ZERO;
                                if (w_row_last) begin
                                    r_row        <= ROW_ZERO;
                                    r_frame_done <= 1'b1;
                                    r_frame_cnt  <= r_frame_cnt + 16'd1;
                                    r_state      <= enable ? WAIT_SOF : IDLE;
                                end else begin
                                    r_row <= r_row + ROW_ONE;
                                end
                            end else if (w_col_last || vid.s_axi_video_tlast) begin
                                r_err_line <= 1'b1;
                                r_col      <= COL_ZERO;
                                r_row      <= ROW_ZERO;
                                r_state    <= RESYNC;
                            end else begin
                                r_col <= r_col + COL_ONE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gray_frame_ctrl.md
# gray_frame_ctrl

Frame-level controller placed in front of the lane system's RGB-to-gray converter. It accepts the camera's AXI4-Stream video, locks onto start-of-frame, and forwards only whole, geometry-checked frames to the converter through a one-deep output register. It also tracks column, row and frame position, and reports framing errors so the downstream lane logic never sees a partial or misaligned frame.

## Interface
**Parameters**
- `AXI_WIDTH`, 24, pixel beat width (RGB888).
- `IMG_WIDTH`, 640, pixels per line.
- `IMG_HEIGHT`, 480, lines per frame.
- `COL_W`, `$clog2(IMG_WIDTH)`, column counter width.
- `ROW_W`, `$clog2(IMG_HEIGHT)`, row counter width.

**Ports**
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  arm; sampled at frame boundaries only.
- `s_axi_video_tdata`  in  AXI_WIDTH  camera pixel.
- `s_axi_video_tvalid`  in  1  beat valid.
- `s_axi_video_tuser`  in  1  start-of-frame marker.
- `s_axi_video_tlast`  in  1  end-of-line marker.
- `s_axi_video_tready`  out  1  accept.
- `m_conv_tdata`  out  AXI_WIDTH  pixel to converter.
- `m_conv_tvalid`  out  1  valid.
- `m_conv_tuser`  out  1  first pixel of frame.
- `m_conv_tlast`  out  1  last pixel of line (geometry-generated).
- `m_conv_tready`  in  1  converter ready.
- `frame_start`  out  1  one-cycle pulse when the SOF beat is accepted.
- `frame_done`  out  1  one-cycle pulse when the final beat of a complete frame is accepted.
- `err_line`  out  1  one-cycle pulse on short or long line.
- `err_sof`  out  1  one-cycle pulse on early `tuser`.
- `col`  out  COL_W  column of the next expected beat.
- `row`  out  ROW_W  row of the next expected beat.
- `frame_cnt`  out  16  completed frames, wraps 0xFFFF→0.

## Operation
- **Beat acceptance.** A beat is accepted when `s_axi_video_tvalid && s_axi_video_tready`.
- **Ready.** `s_axi_video_tready = (state != IDLE) && (!m_conv_tvalid || m_conv_tready)`. This is combinational and uses no skid buffer.
- **IDLE.** `tready` is 0 and upstream is stalled. When `enable` is 1, go to WAIT_SOF.
- **WAIT_SOF.**
  - Beats without `tuser` are accepted and discarded.
  - A `tuser` beat is forwarded with `m_conv_tuser=1`, pulses `frame_start`, sets col=1 and row=0, and moves to ACTIVE.
- **ACTIVE.** Every accepted beat is forwarded, and `m_conv_tlast` is driven as `col==IMG_WIDTH-1`.
  - **Normal end of line.** At col=W-1 with `tlast`: col→0, row→row+1.
  - **End of frame.** If this is also row=H-1: pulse `frame_done`, increment `frame_cnt`, clear col and row, then go to WAIT_SOF if `enable` is 1, otherwise IDLE.
  - **Short line.** `tlast` arrives with col<W-1: forward the beat with `m_conv_tlast=1`, pulse `err_line`, go to RESYNC.
  - **Long line.** col=W-1 without `tlast`: forward the beat with `m_conv_tlast=1`, pulse `err_line`, go to RESYNC.
  - **Early SOF.** `tuser` arrives with (col,row)≠(0,0): pulse `err_sof`, treat the beat as a new SOF (forward with `m_conv_tuser=1`, pulse `frame_start`, col=1, row=0), stay in ACTIVE.
  - **Simultaneous errors.** Early SOF takes priority over line errors on the same beat.
- **RESYNC.** Behaves as WAIT_SOF, except that if `enable` is 0 it goes to IDLE.
- **enable deasserted mid-frame.** The current frame is completed. `enable` is checked only on the transition out of a frame.
- **Counter arithmetic.** Counters are unsigned. col and row wrap only through the explicit clears above and never overflow.

## Timing
- **Latency.** 1 cycle from acceptance to `m_conv_tvalid`. The output register holds while `m_conv_tvalid && !m_conv_tready`.
- **Throughput.** Full rate, one beat per cycle, when `m_conv_tready` is held at 1.
- **Pulse timing.** `frame_start`, `frame_done`, `err_line` and `err_sof` are registered. They assert the cycle after the triggering acceptance, for exactly 1 cycle.
- **Reset.** On `rst`, on any cycle including mid-frame:
  - state=IDLE.
  - All outputs are 0: `m_conv_*`, the pulses, col, row, `frame_cnt` and `s_axi_video_tready`.
  - Any in-flight output beat is dropped.
- **enable at reset release.** With `enable` already 1, WAIT_SOF is reached one cycle after reset deasserts.

## Structure
- **Package `gray_ctrl_pkg`.** Holds the state enum (IDLE, WAIT_SOF, ACTIVE, RESYNC) and a default-geometry localparam pair (640/480).
- **Top level.** A single module. The output register is inline; no sub-module is required. The converter is instantiated by the lane top, not inside this block.

## Test plan
All scenarios use W=4, H=2.
- **Clean frame.** `enable=1`, one clean frame of 8 beats (`tuser` on beat 0, `tlast` on beats 3 and 7) with `m_conv_tready=1` → 8 output beats, `m_conv_tlast` on beats 3 and 7, `frame_start` once, `frame_done` once, `frame_cnt`=1.
- **Pre-SOF garbage.** 3 beats without `tuser` before a clean frame → the 3 beats are discarded and only 8 beats are forwarded.
- **Short line.** `tlast` on beat 2 → beat 2 is forwarded with `m_conv_tlast=1`, `err_line` pulses, beats up to the next `tuser` are dropped, and `frame_cnt` is unchanged.
- **Backpressure.** `m_conv_tready` toggles 1,0,0,1 during a frame → no beat is lost or duplicated, `s_axi_video_tready`=0 while the output is full, and data order is preserved.
- **Early SOF.** `tuser` on beat 5 → `err_sof` pulses, `m_conv_tuser=1` on that beat, and row=0, col=1 afterwards.
- **Reset and enable.** `rst` pulsed at beat 4 → all outputs are 0 the next cycle. Separately, `enable` dropped mid-frame → the frame completes, then the block sits in IDLE with `tready=0`.
